// File: rtl/hazard_unit.sv
// EX operand-forward select, load-use stall and branch flush control for the
// 5-stage RV32I pipeline, with saturating stall/flush event counters.
package hazard_unit_pkg;
    typedef enum logic [1:0] {
        ID2EX_BUF   = 2'd0,
        MEM_FORWARD = 2'd1,
        WB_FORWARD  = 2'd2
    } alu_data_sel_t;
endpackage

module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_mem_read_i,
    input  logic                  branch_taken_i,
    input  logic                  ext_stall_i,
    output alu_data_sel_t         alu_rs1_data_sel_c_o,
    output alu_data_sel_t         alu_rs2_data_sel_c_o,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    logic                  ex_valid_q, ex_valid_d;
    logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_ADDR_W-1:0] ex_rs2_q, ex_rs2_d;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic                  ex_reg_write_q, ex_reg_write_d;
    logic                  ex_mem_read_q, ex_mem_read_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
    logic                  mem_reg_write_q, mem_reg_write_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic                  wb_reg_write_q, wb_reg_write_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

    logic luse_c;
    logic flush_c;

    function automatic alu_data_sel_t fwd_sel(
        input logic                  ex_valid,
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  mem_valid,
        input logic                  mem_wr,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic                  wb_valid,
        input logic                  wb_wr,
        input logic [REG_ADDR_W-1:0] wb_rd
    );
        if (!ex_valid || rs == '0) return ID2EX_BUF;
        if (mem_valid && mem_wr && mem_rd == rs) return MEM_FORWARD;
        if (wb_valid && wb_wr && wb_rd == rs) return WB_FORWARD;
        return ID2EX_BUF;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign alu_rs1_data_sel_c_o = fwd_sel(ex_valid_q, ex_rs1_q, mem_valid_q, mem_reg_write_q,
                                          mem_rd_q, wb_valid_q, wb_reg_write_q, wb_rd_q);
    assign alu_rs2_data_sel_c_o = fwd_sel(ex_valid_q, ex_rs2_q, mem_valid_q, mem_reg_write_q,
                                          mem_rd_q, wb_valid_q, wb_reg_write_q, wb_rd_q);

    // A branch in EX squashes the dependent ID instruction, so it overrides the load-use stall.
    always_comb begin
        luse_c  = id_valid_i && ex_valid_q && ex_mem_read_q && ex_reg_write_q &&
                  (ex_rd_q != '0) &&
                  (ex_rd_q == id_rs1_addr_i || ex_rd_q == id_rs2_addr_i);
        flush_c = !ext_stall_i && branch_taken_i;
        stall_o = ext_stall_i || (!branch_taken_i && luse_c);
        flush_o = flush_c;
    end

    always_comb begin
        ex_valid_d      = ex_valid_q;
        ex_rs1_d        = ex_rs1_q;
        ex_rs2_d        = ex_rs2_q;
        ex_rd_d         = ex_rd_q;
        ex_reg_write_d  = ex_reg_write_q;
        ex_mem_read_d   = ex_mem_read_q;
        mem_valid_d     = mem_valid_q;
        mem_rd_d        = mem_rd_q;
        mem_reg_write_d = mem_reg_write_q;
        wb_valid_d      = wb_valid_q;
        wb_rd_d         = wb_rd_q;
        wb_reg_write_d  = wb_reg_write_q;
        stall_cnt_d     = stall_cnt_q;
        flush_cnt_d     = flush_cnt_q;
        if (!ext_stall_i) begin
            wb_valid_d      = mem_valid_q;
            wb_rd_d         = mem_rd_q;
            wb_reg_write_d  = mem_reg_write_q;
            mem_valid_d     = ex_valid_q;
            mem_rd_d        = ex_rd_q;
            mem_reg_write_d = ex_reg_write_q;
            ex_valid_d      = id_valid_i && !flush_c && !luse_c;
            ex_rs1_d        = id_rs1_addr_i;
            ex_rs2_d        = id_rs2_addr_i;
            ex_rd_d         = id_rd_addr_i;
            ex_reg_write_d  = id_reg_write_i;
            ex_mem_read_d   = id_mem_read_i;
            if (flush_c) begin
                flush_cnt_d = sat_inc(flush_cnt_q);
            end else if (luse_c) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end
        end
    end

    // Slot valids and counters carry reset; slot payload is don't-care while invalid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            mem_valid_q <= mem_valid_d;
            wb_valid_q  <= wb_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        ex_rs1_q        <= ex_rs1_d;
        ex_rs2_q        <= ex_rs2_d;
        ex_rd_q         <= ex_rd_d;
        ex_reg_write_q  <= ex_reg_write_d;
        ex_mem_read_q   <= ex_mem_read_d;
        mem_rd_q        <= mem_rd_d;
        mem_reg_write_q <= mem_reg_write_d;
        wb_rd_q         <= wb_rd_d;
        wb_reg_write_q  <= wb_reg_write_d;
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
